// File: rtl/rpc_wr_phy.sv
// RPC DRAM write PHY: preamble, DQS-strobed data beats, postamble.
// Pad-facing outputs are all registered; data_ready_o decodes state.
module rpc_wr_phy #(
  parameter int PRE_CYC  = 2,
  parameter int POST_CYC = 1,
  parameter int LEN_W    = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             data_valid_i,
  input  logic [15:0]      data_i,
  output logic             data_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o,
  output logic [15:0]      out_db_o,
  output logic             out_dqs_o,
  output logic             out_dqsn_o,
  output logic             oe_db_o,
  output logic             oe_dqs_o,
  output logic             ie_db_o,
  output logic             ie_dqs_o,
  output logic             pd_en_db_o,
  output logic             pd_en_dqs_o
);

  localparam int PW = $clog2(PRE_CYC + 1);
  localparam int QW = $clog2(POST_CYC + 1);

  typedef enum logic [1:0] {
    IDLE, PRE, DATA, POST
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W:0]   cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [QW-1:0]    post_q, post_d;
  logic [15:0]      db_q, db_d;
  logic             dqs_q, dqs_d;
  logic             dqsn_q;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             und_q, und_d;
  logic             ie_q;
  logic             pd_q;

  // DATA is entered one cycle before the first beat is visible, since
  // the registered pads lag the accept edge by a cycle.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    post_d  = post_q;
    db_d    = db_q;
    dqs_d   = dqs_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    und_d   = und_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d   = len_i;
          und_d   = 1'b0;
          cnt_d   = '0;
          pre_d   = '0;
          post_d  = '0;
          oe_d    = 1'b1;
          busy_d  = 1'b1;
          db_d    = '0;
          dqs_d   = 1'b0;
          state_d = (PRE_CYC <= 1) ? DATA : PRE;
        end
      end
      PRE: begin
        if (32'(pre_q) + 2 >= PRE_CYC) begin
          state_d = DATA;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      DATA: begin
        if (data_valid_i) begin
          db_d  = data_i;
          dqs_d = ~dqs_q;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == {1'b0, len_q}) begin
            state_d = POST;
          end
        end else begin
          und_d = 1'b1;
        end
      end
      POST: begin
        if (32'(post_q) >= POST_CYC) begin
          state_d = IDLE;
          done_d  = 1'b1;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          post_d = post_q + 1'b1;
          db_d   = '0;
          dqs_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
      post_q  <= '0;
      db_q    <= '0;
      dqs_q   <= 1'b0;
      dqsn_q  <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      und_q   <= 1'b0;
      ie_q    <= 1'b1;
      pd_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      post_q  <= post_d;
      db_q    <= db_d;
      dqs_q   <= dqs_d;
      dqsn_q  <= ~dqs_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      und_q   <= und_d;
      ie_q    <= ~busy_d;
      pd_q    <= ~oe_d;
    end
  end

  assign data_ready_o = (state_q == DATA);
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign underrun_o   = und_q;
  assign out_db_o     = db_q;
  assign out_dqs_o    = dqs_q;
  assign out_dqsn_o   = dqsn_q;
  assign oe_db_o      = oe_q;
  assign oe_dqs_o     = oe_q;
  assign ie_db_o      = ie_q;
  assign ie_dqs_o     = ie_q;
  assign pd_en_db_o   = pd_q;
  assign pd_en_dqs_o  = pd_q;

endmodule

// File: tb/tb_rpc_wr_phy.sv
// Scoreboard bench for rpc_wr_phy: per-burst expected pad trace
// built from burst rules, checked every cycle by a monitor.
module tb_rpc_wr_phy;
  localparam int PRE  = 2;
  localparam int POST = 1;
  localparam int LW   = 6;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b1;
  logic          start_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic          data_valid_i = 1'b0;
  logic [15:0]   data_i = '0;
  logic          data_ready_o, busy_o, done_o, underrun_o;
  logic [15:0]   out_db_o;
  logic          out_dqs_o, out_dqsn_o;
  logic          oe_db_o, oe_dqs_o, ie_db_o, ie_dqs_o;
  logic          pd_en_db_o, pd_en_dqs_o;

  rpc_wr_phy #(.PRE_CYC(PRE), .POST_CYC(POST), .LEN_W(LW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
    .data_valid_i(data_valid_i), .data_i(data_i),
    .data_ready_o(data_ready_o), .busy_o(busy_o), .done_o(done_o),
    .underrun_o(underrun_o), .out_db_o(out_db_o),
    .out_dqs_o(out_dqs_o), .out_dqsn_o(out_dqsn_o),
    .oe_db_o(oe_db_o), .oe_dqs_o(oe_dqs_o),
    .ie_db_o(ie_db_o), .ie_dqs_o(ie_dqs_o),
    .pd_en_db_o(pd_en_db_o), .pd_en_dqs_o(pd_en_dqs_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int          c;
    logic [15:0] db;
    logic        dqs, oe, busy, done, und, rdy;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic        exp_und = 1'b0;
  logic [15:0] dat [0:63];

  function automatic logic [27:0] expv(exp_t e);
    return {e.db, e.dqs, ~e.dqs, e.oe, e.oe, e.busy, e.done, e.und,
            e.rdy, ~e.busy, ~e.busy, ~e.oe, ~e.oe};
  endfunction

  function automatic logic [27:0] actv();
    return {out_db_o, out_dqs_o, out_dqsn_o, oe_db_o, oe_dqs_o, busy_o,
            done_o, underrun_o, data_ready_o, ie_db_o, ie_dqs_o,
            pd_en_db_o, pd_en_dqs_o};
  endfunction

  task automatic chk(input string nm, input logic [27:0] a,
                     input logic [27:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, a, e);
    end
  endtask

  function automatic void push(int c, logic [15:0] db, logic dqs,
                               logic oe, logic busy, logic done,
                               logic und, logic rdy);
    exp_t e;
    e.c = c; e.db = db; e.dqs = dqs; e.oe = oe;
    e.busy = busy; e.done = done; e.und = und; e.rdy = rdy;
    sb.push_back(e);
  endfunction

  // Monitor: pops the record due this cycle, else expects idle pads.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].c < cyc) begin
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_record cyc=%0d got=none exp_cyc=%0d",
                 cyc, e.c);
      end
      if (sb.size() > 0 && sb[0].c == cyc) begin
        e = sb.pop_front();
        chk("burst", actv(), expv(e));
        exp_und = e.und;
      end else begin
        e = '0;
        e.und = exp_und;
        chk("idle", actv(), expv(e));
      end
    end
  end

  task automatic idle(input int n);
    start_i = 1'b0;
    data_valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // vmode: 0 valid always, 1 random, 2 two stall cycles after beat 1
  task automatic burst(input int len, input int vmode, input bit hold,
                       input int rst_r);
    int          n, r, b, c0, rdone;
    bit          und, dq, v;
    logic [15:0] cur;
    bit          vld [0:511];
    bit          has [0:511];
    logic [15:0] pres [0:511];
    n = len + 1;
    c0 = cyc;
    foreach (has[i]) has[i] = 1'b0;
    for (r = 1; r <= PRE; r++)
      push(c0 + r, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, r == PRE);
    b = 0; cur = '0; dq = 1'b0; und = 1'b0; r = PRE;
    while (b < n) begin
      case (vmode)
        0: v = 1'b1;
        1: v = ($urandom_range(0, 3) != 0) || (r > 400);
        default: v = !(r == PRE + 2 || r == PRE + 3);
      endcase
      vld[r] = v; has[r] = 1'b1; pres[r] = dat[b];
      if (v) begin
        cur = dat[b];
        dq = !dq;
        b++;
      end else begin
        und = 1'b1;
      end
      r++;
      push(c0 + r, cur, dq, 1'b1, 1'b1, 1'b0, und, b < n);
    end
    for (int p = 0; p < POST; p++) begin
      r++;
      push(c0 + r, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, und, 1'b0);
    end
    r++;
    push(c0 + r, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, und, 1'b0);
    rdone = r;
    start_i = 1'b1;
    len_i = LW'(len);
    data_valid_i = 1'($urandom_range(0, 1));
    data_i = 16'($urandom);
    for (r = 1; r < rdone; r++) begin
      @(posedge clk);
      #1;
      if (r == rst_r) begin
        sb.delete();
        start_i = 1'b0;
        data_valid_i = 1'b0;
        #1 rst_ni = 1'b0;
        #1 chk("async_rst", actv(), {16'h0, 8'b01000000, 4'hf});
        exp_und = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_ni = 1'b1;
        return;
      end
      start_i = hold ? 1'b1 : 1'($urandom_range(0, 1));
      len_i = LW'($urandom);
      data_valid_i = has[r] ? vld[r] : 1'($urandom_range(0, 1));
      data_i = has[r] ? pres[r] : 16'($urandom);
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    data_valid_i = 1'b0;
  endtask

  task automatic rand_dat();
    foreach (dat[i]) dat[i] = 16'($urandom);
  endtask

  initial begin
    bit hold;
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_ni = 1'b1;
    idle(3);
    dat[0] = 16'h1111; dat[1] = 16'h2222;
    dat[2] = 16'h3333; dat[3] = 16'h4444;
    burst(3, 0, 1'b0, -1);
    idle(3);
    dat[0] = 16'hA5A5;
    burst(0, 0, 1'b0, -1);
    idle(3);
    rand_dat();
    burst(3, 2, 1'b0, -1);
    idle(3);
    rand_dat();
    burst(3, 0, 1'b0, PRE + 3);
    idle(3);
    rand_dat();
    burst(3, 0, 1'b0, -1);
    idle(2);
    rand_dat();
    burst(5, 1, 1'b1, -1);
    rand_dat();
    burst(2, 0, 1'b0, -1);
    idle(2);
    rand_dat();
    burst(63, 0, 1'b0, -1);
    idle(3);
    for (int k = 0; k < 16; k++) begin
      rand_dat();
      hold = 1'($urandom_range(0, 1));
      burst((k % 3 == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7),
            1, hold, -1);
      if (!hold) idle($urandom_range(0, 3));
    end
    idle(2);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rpc_wr_phy.md
RPC_WR_PHY -- requirements
Module: rpc_wr_phy

Interface
REQ-001 SHALL have parameter PRE_CYC, default 2, meaning the number of DQS preamble cycles (minimum 1).
REQ-002 SHALL have parameter POST_CYC, default 1, meaning the number of DQS postamble cycles (minimum 1).
REQ-003 SHALL have parameter LEN_W, default 6, meaning the width of the burst-length field.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start_i  input  1  write-burst request; sampled only in IDLE.
REQ-007 SHALL have port len_i  input  LEN_W  burst beats minus one; captured with start_i.
REQ-008 SHALL have port data_valid_i  input  1  write beat valid.
REQ-009 SHALL have port data_i  input  16  write beat.
REQ-010 SHALL have port data_ready_o  output  1  beat accept; transfer occurs when valid and ready are both high.
REQ-011 SHALL have port busy_o  output  1  burst in progress.
REQ-012 SHALL have port done_o  output  1  one-cycle burst-complete pulse.
REQ-013 SHALL have port underrun_o  output  1  sticky stall flag; cleared on the next accepted start.
REQ-014 SHALL have ports out_db_o (16), out_dqs_o (1) and out_dqsn_o (1), all outputs, carrying pad-frame output data and strobe.
REQ-015 SHALL have ports oe_db_o, oe_dqs_o, ie_db_o, ie_dqs_o, pd_en_db_o and pd_en_dqs_o, all outputs of width 1, carrying pad-frame output-enable, input-enable and pull-down controls.

Function
REQ-016 SHALL implement the FSM IDLE -> PRE -> DATA -> POST -> IDLE, with no other states.
REQ-017 SHALL register every pad-facing output; data_ready_o SHALL be combinational from state (high only in DATA, while beats remain).
REQ-018 SHALL, in IDLE with start_i=1, capture len_i, clear underrun_o and enter PRE; start_i SHALL be ignored in all other states.
REQ-019 SHALL define cycle 1 as the cycle after the start edge.
REQ-020 SHALL, during cycles 1..PRE_CYC, drive oe_db_o=oe_dqs_o=1, out_dqs_o=0, out_dqsn_o=1, out_db_o=0 and busy_o=1.
REQ-021 SHALL give beat count N=len_i+1, range 1..2^LEN_W; the beat counter SHALL be sized so that N=2^LEN_W does not wrap.
REQ-022 SHALL make a beat accepted at an edge visible on out_db_o in the following cycle, with out_dqs_o toggling in that same cycle and out_dqsn_o=~out_dqs_o.
REQ-023 SHALL drive out_dqs_o=1 with the first beat, so beat i carries out_dqs_o = (i even).
REQ-024 SHALL place beat i in cycle PRE_CYC+1+i with zero stall when data_valid_i is held high.
REQ-025 SHALL, on a DATA-state edge with data_valid_i=0 (stall), hold out_db_o and out_dqs_o unchanged, set underrun_o and not advance the counter.
REQ-026 SHALL, after the N-th beat is visible, drive out_dqs_o=0, out_dqsn_o=1, out_db_o=0 for POST_CYC cycles with oe_* still 1.
REQ-027 SHALL, in the cycle after the postamble, set oe_db_o=oe_dqs_o=0 and busy_o=0 and pulse done_o=1 for exactly one cycle.
REQ-028 SHALL accept a new start_i in that same done cycle.
REQ-029 SHALL drive ie_db_o=ie_dqs_o=~busy_o, pd_en_db_o=~oe_db_o and pd_en_dqs_o=~oe_dqs_o at all times.
REQ-030 SHALL give oe_db_o and oe_dqs_o identical timing; they SHALL never differ.

Reset
REQ-031 SHALL, on rst_ni=0 at any time including mid-burst, immediately force IDLE, out_db_o=0, out_dqs_o=0, out_dqsn_o=1, oe_*=0, busy_o=0, done_o=0, underrun_o=0, ie_*=1 and pd_en_*=1.
REQ-032 SHALL discard any partial burst on reset and emit no done_o pulse for it.
REQ-033 SHALL, after rst_ni is released, leave outputs at their reset values until the first accepted start_i.

Verification
REQ-034 SHALL be verified with PRE_CYC=2, POST_CYC=1, len_i=3, valid always high, data 0x1111..0x4444 -> oe high cycles 1-7; beats in cycles 3-6 with dqs 1,0,1,0; cycle 7 dqs=0, db=0; cycle 8 done_o=1, oe=0.
REQ-035 SHALL be verified with len_i=0, single beat 0xA5A5 -> beat in cycle 3 with dqs=1, dqs=0 in cycle 4, done_o in cycle 5.
REQ-036 SHALL be verified with len_i=3 and data_valid_i low for 2 cycles after beat 1 -> db and dqs held for 2 extra cycles, underrun_o=1 until the next start, done_o in cycle 10.
REQ-037 SHALL be verified with rst_ni asserted during beat 2 -> all outputs at reset values asynchronously, no done_o, and a clean burst on the next start.
REQ-038 SHALL be verified with start_i held high through a burst and into the done cycle -> second burst begins with its cycle 1 immediately after the done cycle; no mid-burst restart.
REQ-039 SHALL be verified with len_i=2^LEN_W-1 -> exactly 64 beats with dqs alternating, ending dqs=0, then done_o.
